// File: rtl/emesh_pkg.sv
// Shared eMesh definitions: packet width, field bit positions, read credit default.
package emesh_pkg;

  localparam int PW             = 104;
  localparam int MAX_RD_DEFAULT = 8;

  // Packet field bit positions
  localparam int WRITE_BIT    = 0;
  localparam int DATAMODE_LSB = 1;
  localparam int DATAMODE_MSB = 2;
  localparam int CTRLMODE_LSB = 3;
  localparam int CTRLMODE_MSB = 7;
  localparam int DSTADDR_LSB  = 8;
  localparam int DSTADDR_MSB  = 39;
  localparam int DATA_LSB     = 40;
  localparam int DATA_MSB     = 71;
  localparam int SRCADDR_LSB  = 72;
  localparam int SRCADDR_MSB  = 103;

  // Assemble a packet from its fields
  function automatic logic [PW-1:0] make_packet(
    input logic        write,
    input logic [1:0]  datamode,
    input logic [4:0]  ctrlmode,
    input logic [31:0] dstaddr,
    input logic [31:0] data,
    input logic [31:0] srcaddr
  );
    logic [PW-1:0] p;
    p = '0;
    p[WRITE_BIT]                 = write;
    p[DATAMODE_MSB:DATAMODE_LSB] = datamode;
    p[CTRLMODE_MSB:CTRLMODE_LSB] = ctrlmode;
    p[DSTADDR_MSB:DSTADDR_LSB]   = dstaddr;
    p[DATA_MSB:DATA_LSB]         = data;
    p[SRCADDR_MSB:SRCADDR_LSB]   = srcaddr;
    return p;
  endfunction

endpackage

// File: rtl/emesh_req_splitter_if.sv
// Request/response signals between upstream eMesh, the splitter and the AXI bridge.
interface emesh_req_splitter_if #(
  parameter int PW = 104,
  parameter int CW = 4
);
  logic          in_access;
  logic [PW-1:0] in_packet;
  logic          in_wait;
  logic          wr_access;
  logic [PW-1:0] wr_packet;
  logic          wr_wait;
  logic          rd_access;
  logic [PW-1:0] rd_packet;
  logic          rd_wait;
  logic          rr_access;
  logic          rr_wait;
  logic [CW-1:0] rd_outstanding;
  logic          err_underflow;

  // Splitter side
  modport slave (
    input  in_access, in_packet, wr_wait, rd_wait, rr_access, rr_wait,
    output in_wait, wr_access, wr_packet, rd_access, rd_packet,
           rd_outstanding, err_underflow
  );

  // Environment side (upstream + bridge)
  modport master (
    output in_access, in_packet, wr_wait, rd_wait, rr_access, rr_wait,
    input  in_wait, wr_access, wr_packet, rd_access, rd_packet,
           rd_outstanding, err_underflow
  );
endinterface

// File: rtl/emesh_hold_reg.sv
// One-entry valid/packet holding register for one output channel.
module emesh_hold_reg #(
  parameter int PW = 104
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_packet,
  input  logic          out_wait,
  output logic          valid,
  output logic [PW-1:0] packet
);

  logic          valid_reg;
  logic [PW-1:0] packet_reg;

  // Load has priority over drain; packet is frozen while the consumer waits
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      packet_reg <= '0;
    end else if (load) begin
      valid_reg  <= 1'b1;
      packet_reg <= load_packet;
    end else if (valid_reg && !out_wait) begin
      valid_reg  <= 1'b0;
    end
  end

  assign valid  = valid_reg;
  assign packet = packet_reg;

endmodule

// File: rtl/emesh_req_splitter.sv
// Routes upstream eMesh requests to write/read bridge channels, bounding outstanding reads.
module emesh_req_splitter #(
  parameter int PW     = emesh_pkg::PW,
  parameter int MAX_RD = emesh_pkg::MAX_RD_DEFAULT,
  parameter int CW     = $clog2(MAX_RD + 1)
) (
  input logic                 clk,
  input logic                 reset,
  emesh_req_splitter_if.slave bus
);
  import emesh_pkg::*;

  logic          wr_valid;
  logic          rd_valid;
  logic [PW-1:0] wr_packet;
  logic [PW-1:0] rd_packet;
  logic          in_wait;
  logic          in_fire;
  logic          wr_load;
  logic          rd_load;
  logic          rd_issue;
  logic          rr_accept;
  logic [CW:0]   credit_sum;
  logic          credit_full;

  logic [CW-1:0] rd_outstanding_reg, rd_outstanding_next;
  logic          err_underflow_reg, err_underflow_next;

  // A read sitting in the rd register already owns a credit, so count it too.
  // in_wait never looks at the packet type, which keeps reads and writes in order.
  assign credit_sum  = {1'b0, rd_outstanding_reg} + {{CW{1'b0}}, rd_valid};
  assign credit_full = credit_sum >= (CW+1)'(MAX_RD);
  assign in_wait     = (wr_valid && bus.wr_wait) || (rd_valid && bus.rd_wait) || credit_full;

  assign in_fire   = bus.in_access && !in_wait;
  assign wr_load   = in_fire && bus.in_packet[WRITE_BIT];
  assign rd_load   = in_fire && !bus.in_packet[WRITE_BIT];
  assign rd_issue  = rd_valid && !bus.rd_wait;
  assign rr_accept = bus.rr_access && !bus.rr_wait;

  emesh_hold_reg #(.PW(PW)) u_wr_hold (
    .clk         (clk),
    .reset       (reset),
    .load        (wr_load),
    .load_packet (bus.in_packet),
    .out_wait    (bus.wr_wait),
    .valid       (wr_valid),
    .packet      (wr_packet)
  );

  emesh_hold_reg #(.PW(PW)) u_rd_hold (
    .clk         (clk),
    .reset       (reset),
    .load        (rd_load),
    .load_packet (bus.in_packet),
    .out_wait    (bus.rd_wait),
    .valid       (rd_valid),
    .packet      (rd_packet)
  );

  // Credit count next value: issue adds, response subtracts, both cancel, zero saturates
  always_comb begin
    rd_outstanding_next = rd_outstanding_reg;
    err_underflow_next  = err_underflow_reg;
    if (rd_issue && !rr_accept) begin
      rd_outstanding_next = rd_outstanding_reg + 1'b1;
    end else if (rr_accept && !rd_issue) begin
      if (rd_outstanding_reg == '0) begin
        err_underflow_next = 1'b1;
      end else begin
        rd_outstanding_next = rd_outstanding_reg - 1'b1;
      end
    end
  end

  // Credit count and sticky underflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_outstanding_reg <= '0;
      err_underflow_reg  <= 1'b0;
    end else begin
      rd_outstanding_reg <= rd_outstanding_next;
      err_underflow_reg  <= err_underflow_next;
    end
  end

  assign bus.in_wait        = in_wait;
  assign bus.wr_access      = wr_valid;
  assign bus.wr_packet      = wr_packet;
  assign bus.rd_access      = rd_valid;
  assign bus.rd_packet      = rd_packet;
  assign bus.rd_outstanding = rd_outstanding_reg;
  assign bus.err_underflow  = err_underflow_reg;

endmodule

// File: tb/tb_emesh_req_splitter.sv
// Self-checking bench for emesh_req_splitter: directed scenarios plus random traffic
// compared every cycle against a queue-based model.
module tb_emesh_req_splitter;
  import emesh_pkg::*;

  localparam int TB_PW     = 104;
  localparam int TB_MAX_RD = 8;
  localparam int TB_CW     = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  bit   started;

  emesh_req_splitter_if #(.PW(TB_PW), .CW(TB_CW)) bus ();

  emesh_req_splitter #(.PW(TB_PW), .MAX_RD(TB_MAX_RD), .CW(TB_CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [TB_PW-1:0] wr_q[$];
  logic [TB_PW-1:0] rd_q[$];
  int               m_cnt;
  bit               m_err;
  bit               m_acc;
  bit               m_issue;
  bit               m_resp;

  function automatic bit model_in_wait();
    return (wr_q.size() != 0 && bus.wr_wait) ||
           (rd_q.size() != 0 && bus.rd_wait) ||
           (m_cnt + rd_q.size() >= TB_MAX_RD);
  endfunction

  // Model advances on each rising edge using inputs that are stable there
  always @(posedge clk) begin
    if (reset) begin
      wr_q.delete();
      rd_q.delete();
      m_cnt = 0;
      m_err = 0;
    end else begin
      m_acc   = bus.in_access && !model_in_wait();
      m_issue = rd_q.size() != 0 && !bus.rd_wait;
      m_resp  = bus.rr_access && !bus.rr_wait;
      if (m_issue && !m_resp) m_cnt = m_cnt + 1;
      else if (m_resp && !m_issue) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt = m_cnt - 1;
      end
      if (wr_q.size() != 0 && !bus.wr_wait) void'(wr_q.pop_front());
      if (m_issue) void'(rd_q.pop_front());
      if (m_acc) begin
        if (bus.in_packet[0]) wr_q.push_back(bus.in_packet);
        else rd_q.push_back(bus.in_packet);
        $display("txn t=%0t %s dst=%h data=%h src=%h", $time,
                 bus.in_packet[0] ? "WR" : "RD", bus.in_packet[39:8],
                 bus.in_packet[71:40], bus.in_packet[103:72]);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("wr_access", 128'(bus.wr_access), 128'(wr_q.size() != 0));
      if (wr_q.size() != 0) chk("wr_packet", 128'(bus.wr_packet), 128'(wr_q[0]));
      chk("rd_access", 128'(bus.rd_access), 128'(rd_q.size() != 0));
      if (rd_q.size() != 0) chk("rd_packet", 128'(bus.rd_packet), 128'(rd_q[0]));
      chk("in_wait", 128'(bus.in_wait), 128'(model_in_wait()));
      chk("rd_outstanding", 128'(bus.rd_outstanding), 128'(m_cnt));
      chk("err_underflow", 128'(bus.err_underflow), 128'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_access = 1'b0;
    bus.in_packet = '0;
    bus.wr_wait   = 1'b0;
    bus.rd_wait   = 1'b0;
    bus.rr_access = 1'b0;
    bus.rr_wait   = 1'b0;
  endtask

  task automatic send(input logic [TB_PW-1:0] p);
    bus.in_access = 1'b1;
    bus.in_packet = p;
    tick();
    bus.in_access = 1'b0;
  endtask

  task automatic respond(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rr_access = 1'b1;
      tick();
    end
    bus.rr_access = 1'b0;
  endtask

  logic [TB_PW-1:0] pkt_w;
  logic [TB_PW-1:0] pkt_r;

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    started = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset   = 1'b0;
    started = 1;

    // Reset state
    chk("rst_wr_access", 128'(bus.wr_access), 128'(0));
    chk("rst_rd_access", 128'(bus.rd_access), 128'(0));
    chk("rst_wr_packet", 128'(bus.wr_packet), 128'(0));
    chk("rst_rd_packet", 128'(bus.rd_packet), 128'(0));
    chk("rst_count", 128'(bus.rd_outstanding), 128'(0));
    chk("rst_err", 128'(bus.err_underflow), 128'(0));
    chk("rst_in_wait", 128'(bus.in_wait), 128'(0));

    // Write pass-through, one cycle latency
    pkt_w = make_packet(1'b1, 2'd2, 5'd0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000);
    chk("pkt_w_literal", 128'(pkt_w), 128'h0000000_0DEADBEEF_80000010_05);
    send(pkt_w);
    chk("wr_pass_access", 128'(bus.wr_access), 128'(1));
    chk("wr_pass_packet", 128'(bus.wr_packet), 128'(pkt_w));
    chk("wr_pass_rd_idle", 128'(bus.rd_access), 128'(0));
    tick();
    chk("wr_pass_drained", 128'(bus.wr_access), 128'(0));

    // Read stall for five cycles
    pkt_r = make_packet(1'b0, 2'd2, 5'd0, 32'h8000_0020, 32'h0, 32'h1234_5678);
    bus.rd_wait = 1'b1;
    send(pkt_r);
    for (int c = 1; c <= 5; c++) begin
      chk("stall_rd_access", 128'(bus.rd_access), 128'(1));
      chk("stall_rd_packet", 128'(bus.rd_packet), 128'(pkt_r));
      chk("stall_in_wait", 128'(bus.in_wait), 128'(1));
      chk("stall_count", 128'(bus.rd_outstanding), 128'(0));
      if (c < 5) tick();
    end
    bus.rd_wait = 1'b0;
    tick();
    chk("stall_count_after", 128'(bus.rd_outstanding), 128'(1));
    chk("stall_rd_drained", 128'(bus.rd_access), 128'(0));
    respond(1);
    chk("stall_count_zero", 128'(bus.rd_outstanding), 128'(0));

    // Credit limit
    for (int i = 0; i < TB_MAX_RD; i++)
      send(make_packet(1'b0, 2'd2, 5'd0, 32'h9000_0000 + 32'(i * 4), 32'h0, 32'(i)));
    tick();
    chk("limit_count", 128'(bus.rd_outstanding), 128'(8));
    chk("limit_in_wait", 128'(bus.in_wait), 128'(1));
    send(make_packet(1'b1, 2'd0, 5'd0, 32'hA000_0000, 32'h5555_AAAA, 32'h0));
    chk("limit_ignored", 128'(bus.wr_access), 128'(0));
    respond(1);
    chk("limit_count_7", 128'(bus.rd_outstanding), 128'(7));
    chk("limit_released", 128'(bus.in_wait), 128'(0));
    respond(7);
    chk("limit_count_0", 128'(bus.rd_outstanding), 128'(0));

    // Issue and response in the same cycle at count 3
    for (int i = 0; i < 3; i++)
      send(make_packet(1'b0, 2'd1, 5'd0, 32'hB000_0000 + 32'(i), 32'h0, 32'h0));
    tick();
    chk("simul_pre", 128'(bus.rd_outstanding), 128'(3));
    send(make_packet(1'b0, 2'd1, 5'd0, 32'hB000_0100, 32'h0, 32'h0));
    respond(1);
    chk("simul_count", 128'(bus.rd_outstanding), 128'(3));
    respond(3);

    // Underflow
    chk("uf_pre", 128'(bus.rd_outstanding), 128'(0));
    respond(1);
    chk("uf_count", 128'(bus.rd_outstanding), 128'(0));
    chk("uf_err", 128'(bus.err_underflow), 128'(1));
    tick();
    chk("uf_sticky", 128'(bus.err_underflow), 128'(1));

    // Reset while a write is stalled and a read is outstanding
    send(make_packet(1'b0, 2'd2, 5'd0, 32'hC000_0000, 32'h0, 32'h0));
    tick();
    bus.wr_wait = 1'b1;
    send(make_packet(1'b1, 2'd2, 5'd0, 32'hC000_0004, 32'hCAFE_F00D, 32'h0));
    chk("rst_mid_wr_held", 128'(bus.wr_access), 128'(1));
    chk("rst_mid_count", 128'(bus.rd_outstanding), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_wr_access", 128'(bus.wr_access), 128'(0));
    chk("rst_mid_zero_count", 128'(bus.rd_outstanding), 128'(0));
    chk("rst_mid_err", 128'(bus.err_underflow), 128'(0));
    bus.wr_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_emit", 128'({bus.wr_access, bus.rd_access}), 128'(0));
    end

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bus.in_access = ($urandom_range(0, 99) < 60);
      bus.in_packet = make_packet(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
                                  $urandom, $urandom, $urandom);
      bus.wr_wait   = ($urandom_range(0, 99) < 30);
      bus.rd_wait   = ($urandom_range(0, 99) < 30);
      bus.rr_access = ($urandom_range(0, 99) < 35);
      bus.rr_wait   = ($urandom_range(0, 99) < 25);
      reset         = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
